fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam int          INST_W           = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {instruction, pc} entries with a registered head so that
// the memory read data never reaches the decode-side outputs combinationally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_inc;
    logic [AW:0]   count_reg, count_next;
    logic [W-1:0]  head_reg, head_next;
    logic          valid_reg;
    logic          pop_ok;

    assign pop_ok     = pop && (count_reg != '0);
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Head register tracks whatever entry will sit at the front after this edge.
    always_comb begin
        head_next  = head_reg;
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else begin
            count_next = count_reg + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop_ok};
            if (pop_ok && count_reg > (AW+1)'(1)) begin
                head_next = mem[rd_ptr_inc];
            end else if (push && (count_reg == '0 || (pop_ok && count_reg == (AW+1)'(1)))) begin
                head_next = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            if (clear) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push)   wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop_ok) rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_next;
            head_reg  <= head_next;
            valid_reg <= (count_next != '0);
        end
    end

    assign head_valid = valid_reg;
    assign head_data  = head_reg;
    assign count      = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request memory FSM feeding a prefetch queue.
// Optional redirect-flush counter enabled by defining FETCH_FLUSH_CNT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [31:0]       redirect_addr,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       inst_pc,
    input  logic              inst_ready
`ifdef FETCH_FLUSH_CNT_EN
    ,
    output logic [15:0]       flush_cnt
`endif
);

    fetch_state_e          state_reg, state_next;
    logic [31:0]           fetch_pc_reg, fetch_pc_next;
    logic [31:0]           addr_reg, addr_next;
    logic [31:0]           redirect_pc, inc_pc;
    logic                  q_push, q_clear, pop_fire;
    logic [$clog2(DEPTH):0] q_count;
    logic [INST_W+31:0]    q_head;

    assign redirect_pc = align_word(redirect_addr);
    assign inc_pc      = fetch_pc_reg + 32'(PC_STEP);
    assign pop_fire    = inst_valid && inst_ready;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        addr_next     = addr_reg;
        q_push        = 1'b0;
        q_clear       = 1'b0;
        case (state_reg)
            IDLE: begin
                // A redirect from idle issues straight to the new target.
                if (redirect) begin
                    q_clear       = 1'b1;
                    fetch_pc_next = redirect_pc;
                    addr_next     = redirect_pc;
                    state_next    = WAIT;
                end else if (32'(q_count) < 32'(DEPTH)) begin
                    addr_next  = fetch_pc_reg;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    q_clear       = 1'b1;
                    fetch_pc_next = redirect_pc;
                    state_next    = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    q_push        = 1'b1;
                    fetch_pc_next = inc_pc;
                    if (32'(q_count) + 32'd1 - 32'(pop_fire) < 32'(DEPTH)) begin
                        addr_next = inc_pc;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (redirect) fetch_pc_next = redirect_pc;
                if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            addr_reg     <= addr_next;
        end
    end

    assign imem_req  = (state_reg != IDLE);
    assign imem_addr = addr_reg;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (INST_W + 32)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (q_clear),
        .push       (q_push),
        .push_data  ({imem_rdata, addr_reg}),
        .pop        (pop_fire),
        .head_valid (inst_valid),
        .head_data  (q_head),
        .count      (q_count)
    );

    assign inst    = q_head[INST_W+31:32];
    assign inst_pc = q_head[31:0];

`ifdef FETCH_FLUSH_CNT_EN
    logic        flush_event;
    logic [15:0] flush_cnt_reg;

    // Only redirects that actually throw away fetched or in-flight work count.
    assign flush_event = redirect &&
                         ((state_reg == IDLE && q_count != '0) || state_reg == WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_reg <= '0;
        end else if (flush_event && flush_cnt_reg != 16'hFFFF) begin
            flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign flush_cnt = flush_cnt_reg;
`endif

endmodule
